// File: rtl/exec_unit_md.sv
// ----------------------------------------------------------------------------
// exec_unit_md
//   Execute stage of the pipelined RV32/RV64 core. It contains the integer ALU,
//   branch/jump resolution and an iterative RV32M multiplier/divider.
//   Single-cycle ops produce a registered result one clock after acceptance.
//   MUL takes MUL_LAT cycles and DIV takes XLEN+1 cycles. While either is in
//   flight, in_ready is low.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  issue handshake; an op is accepted on
//                        in_valid & in_ready & ~flush
//   flush                kills the op in flight and the op presented this cycle
//   opcode, f3, m_ext    instruction decode fields (m_ext selects MUL/DIV on OP)
//   alu_op, sign         ALU function (add..sra) and compare signedness
//   op_a, op_b           pre-muxed ALU operands
//   rs1, rs2, pc, imm    raw values for compare, jalr, M ops and targets
//   out_valid            one-cycle completion pulse
//   result, target       writeback data and redirect PC; these hold between pulses
//   reg_wr, pc_src, clear  writeback enable, redirect taken, squash younger ops
//                          (all three are 0 whenever out_valid is 0)
// ----------------------------------------------------------------------------
module exec_unit_md #(
   parameter int XLEN     = 32,
   parameter int MUL_LAT  = 2,
   parameter int DIV_ITER = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   input  logic [6:0]      opcode,
   input  logic [2:0]      f3,
   input  logic            m_ext,
   input  logic [2:0]      alu_op,
   input  logic            sign,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            reg_wr,
   output logic            pc_src,
   output logic [XLEN-1:0] target,
   output logic            clear
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(DIV_ITER + 1);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // output registers
   logic            in_ready_reg, in_ready_next;
   logic            out_valid_reg, out_valid_next;
   logic            reg_wr_reg, reg_wr_next;
   logic            pc_src_reg, pc_src_next;
   logic            clear_reg;
   logic [XLEN-1:0] result_reg, result_next;
   logic [XLEN-1:0] target_reg, target_next;

   // multiplier state: operands carry one extra sign bit so a single signed
   // multiply covers the ss, su and uu variants
   logic [XLEN:0]   mul_a_reg, mul_b_reg;
   logic            mul_hi_reg;
   logic [2:0]      mul_cnt_reg;

   // divider state
   logic [XLEN-1:0] div_q_reg;      // dividend shifts out, quotient shifts in
   logic [XLEN-1:0] div_r_reg;      // partial remainder
   logic [XLEN-1:0] div_d_reg;      // divisor magnitude
   logic [XLEN-1:0] div_dvd_reg;    // raw dividend, for the divide-by-zero remainder
   logic            div_neg_q_reg;
   logic            div_neg_r_reg;
   logic            div_zero_reg;
   logic            div_rem_reg;
   logic [CW-1:0]   div_cnt_reg;

   // ------------------------------------------------------------------------
   // issue decode
   // ------------------------------------------------------------------------
   logic accept, is_m, start_alu, start_mul, start_div;
   logic mul_done, div_done;

   assign accept    = in_valid & in_ready_reg & ~flush;
   assign is_m      = (opcode == OPC_OP) & m_ext;
   assign start_alu = accept & ~is_m;
   assign start_mul = accept & is_m & ~f3[2];
   assign start_div = accept & is_m &  f3[2];

   assign mul_done  = (state_reg == S_MUL) && (mul_cnt_reg == 3'(MUL_LAT - 1));
   // DIV_ITER iteration cycles, then this extra cycle for the sign fixup
   assign div_done  = (state_reg == S_DIV) && (div_cnt_reg == CW'(DIV_ITER));

   // ------------------------------------------------------------------------
   // ALU, compare and target arithmetic
   // ------------------------------------------------------------------------
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] pc_imm, link, jalr_sum, jalr_tgt;
   logic            cmp_eq, cmp_lt, br_taken;

   assign shamt    = op_b[SHW-1:0];
   assign pc_imm   = pc + imm;
   assign link     = pc + XLEN'(4);
   assign jalr_sum = rs1 + imm;
   assign jalr_tgt = jalr_sum & ~XLEN'(1);

   always_comb begin
      alu_out = '0;
      case (alu_op)
         3'd0: alu_out = op_a + op_b;
         3'd1: alu_out = op_a - op_b;
         3'd2: alu_out = op_a ^ op_b;
         3'd3: alu_out = op_a | op_b;
         3'd4: alu_out = op_a & op_b;
         3'd5: alu_out = op_a << shamt;
         3'd6: alu_out = op_a >> shamt;
         3'd7: alu_out = $signed(op_a) >>> shamt;
         default: alu_out = '0;
      endcase
   end

   assign cmp_eq = (rs1 == rs2);
   assign cmp_lt = sign ? ($signed(rs1) < $signed(rs2)) : (rs1 < rs2);

   // f3[2] selects lt/ge, f3[0] inverts; f3 = 01x is not a branch
   always_comb begin
      br_taken = 1'b0;
      case (f3[2:1])
         2'b00:   br_taken = cmp_eq ^ f3[0];
         2'b01:   br_taken = 1'b0;
         default: br_taken = cmp_lt ^ f3[0];
      endcase
   end

   // ------------------------------------------------------------------------
   // multiplier product and divider step/fixup
   // ------------------------------------------------------------------------
   logic [2*XLEN-1:0] mul_ax, mul_bx, mul_prod;
   logic [XLEN-1:0]   mul_res;

   assign mul_ax   = {{(XLEN-1){mul_a_reg[XLEN]}}, mul_a_reg};
   assign mul_bx   = {{(XLEN-1){mul_b_reg[XLEN]}}, mul_b_reg};
   assign mul_prod = mul_ax * mul_bx;
   assign mul_res  = mul_hi_reg ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

   logic [XLEN:0]   div_shift, div_diff;
   logic [XLEN-1:0] div_q_fix, div_r_fix, div_res;

   assign div_shift = {div_r_reg, div_q_reg[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, div_d_reg};

   // MIN / -1 needs no special case: |MIN| / 1 gives MIN with equal signs,
   // so the quotient stays MIN and the remainder is 0.
   always_comb begin
      div_q_fix = div_neg_q_reg ? (~div_q_reg + XLEN'(1)) : div_q_reg;
      div_r_fix = div_neg_r_reg ? (~div_r_reg + XLEN'(1)) : div_r_reg;
      if (div_zero_reg) begin
         div_q_fix = '1;
         div_r_fix = div_dvd_reg;
      end
      div_res = div_rem_reg ? div_r_fix : div_q_fix;
   end

   // ------------------------------------------------------------------------
   // FSM next state and registered output values
   // ------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      out_valid_next = 1'b0;
      reg_wr_next    = 1'b0;
      pc_src_next    = 1'b0;
      result_next    = result_reg;
      target_next    = target_reg;

      case (state_reg)
         S_IDLE: begin
            if (start_mul)      state_next = S_MUL;
            else if (start_div) state_next = S_DIV;
         end
         S_MUL:   if (mul_done) state_next = S_IDLE;
         S_DIV:   if (div_done) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      if (start_alu) begin
         out_valid_next = 1'b1;
         reg_wr_next    = 1'b1;
         result_next    = alu_out;
         target_next    = pc_imm;
         case (opcode)
            OPC_LUI:   result_next = imm;
            OPC_AUIPC: result_next = op_a + op_b;
            OPC_JAL: begin
               result_next = link;
               pc_src_next = 1'b1;
            end
            OPC_JALR: begin
               result_next = link;
               target_next = jalr_tgt;
               pc_src_next = 1'b1;
            end
            OPC_BRANCH: begin
               reg_wr_next = 1'b0;
               pc_src_next = br_taken;
            end
            OPC_STORE: reg_wr_next = 1'b0;
            default: ;
         endcase
      end else if (mul_done) begin
         out_valid_next = 1'b1;
         reg_wr_next    = 1'b1;
         result_next    = mul_res;
      end else if (div_done) begin
         out_valid_next = 1'b1;
         reg_wr_next    = 1'b1;
         result_next    = div_res;
      end

      // flush kills both a completion and anything in flight
      if (flush) begin
         state_next     = S_IDLE;
         out_valid_next = 1'b0;
         reg_wr_next    = 1'b0;
         pc_src_next    = 1'b0;
         result_next    = result_reg;
         target_next    = target_reg;
      end

      in_ready_next = (state_next == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         reg_wr_reg    <= 1'b0;
         pc_src_reg    <= 1'b0;
         clear_reg     <= 1'b0;
         result_reg    <= '0;
         target_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         in_ready_reg  <= in_ready_next;
         out_valid_reg <= out_valid_next;
         reg_wr_reg    <= reg_wr_next;
         pc_src_reg    <= pc_src_next;
         clear_reg     <= pc_src_next & out_valid_next;
         result_reg    <= result_next;
         target_reg    <= target_next;
      end
   end

   // ------------------------------------------------------------------------
   // multiply / divide datapath registers
   // ------------------------------------------------------------------------
   logic          div_signed, div_a_neg, div_b_neg;
   logic [XLEN-1:0] div_a_abs, div_b_abs;

   assign div_signed = ~f3[0];
   assign div_a_neg  = div_signed & rs1[XLEN-1];
   assign div_b_neg  = div_signed & rs2[XLEN-1];
   assign div_a_abs  = div_a_neg ? (~rs1 + XLEN'(1)) : rs1;
   assign div_b_abs  = div_b_neg ? (~rs2 + XLEN'(1)) : rs2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a_reg     <= '0;
         mul_b_reg     <= '0;
         mul_hi_reg    <= 1'b0;
         mul_cnt_reg   <= '0;
         div_q_reg     <= '0;
         div_r_reg     <= '0;
         div_d_reg     <= '0;
         div_dvd_reg   <= '0;
         div_neg_q_reg <= 1'b0;
         div_neg_r_reg <= 1'b0;
         div_zero_reg  <= 1'b0;
         div_rem_reg   <= 1'b0;
         div_cnt_reg   <= '0;
      end else begin
         if (start_mul) begin
            // mulh (001) and mulhsu (010) treat rs1 as signed; only mulh signs rs2
            mul_a_reg   <= {(f3 == 3'b001 || f3 == 3'b010) & rs1[XLEN-1], rs1};
            mul_b_reg   <= {(f3 == 3'b001) & rs2[XLEN-1], rs2};
            mul_hi_reg  <= (f3[1:0] != 2'b00);
            mul_cnt_reg <= '0;
         end else if (state_reg == S_MUL && !mul_done) begin
            mul_cnt_reg <= mul_cnt_reg + 3'd1;
         end

         if (start_div) begin
            div_q_reg     <= div_a_abs;
            div_r_reg     <= '0;
            div_d_reg     <= div_b_abs;
            div_dvd_reg   <= rs1;
            div_neg_q_reg <= div_a_neg ^ div_b_neg;
            div_neg_r_reg <= div_a_neg;
            div_zero_reg  <= (rs2 == '0);
            div_rem_reg   <= f3[1];
            div_cnt_reg   <= '0;
         end else if (state_reg == S_DIV && !div_done) begin
            // restoring step: keep the subtraction only if it did not borrow
            if (!div_diff[XLEN]) begin
               div_r_reg <= div_diff[XLEN-1:0];
               div_q_reg <= {div_q_reg[XLEN-2:0], 1'b1};
            end else begin
               div_r_reg <= div_shift[XLEN-1:0];
               div_q_reg <= {div_q_reg[XLEN-2:0], 1'b0};
            end
            div_cnt_reg <= div_cnt_reg + CW'(1);
         end
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign reg_wr    = reg_wr_reg;
   assign pc_src    = pc_src_reg;
   assign clear     = clear_reg;
   assign result    = result_reg;
   assign target    = target_reg;

endmodule

// File: tb/tb_exec_unit_md.sv
// ----------------------------------------------------------------------------
// tb_exec_unit_md
//   Directed bench for exec_unit_md (XLEN=32, MUL_LAT=2). Each scenario task
//   drives its own vectors and compares outputs against hand-computed values
//   one cycle point at a time, sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_exec_unit_md;

   localparam int XLEN    = 32;
   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = XLEN + 1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            flush = 1'b0;
   logic [6:0]      opcode = '0;
   logic [2:0]      f3 = '0;
   logic            m_ext = 1'b0;
   logic [2:0]      alu_op = '0;
   logic            sign = 1'b0;
   logic [31:0]     op_a = '0, op_b = '0, rs1 = '0, rs2 = '0, pc = '0, imm = '0;
   logic            out_valid;
   logic [31:0]     result;
   logic            reg_wr;
   logic            pc_src;
   logic [31:0]     target;
   logic            clear;

   int checks   = 0;
   int failures = 0;

   exec_unit_md #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .opcode(opcode), .f3(f3), .m_ext(m_ext), .alu_op(alu_op),
      .sign(sign), .op_a(op_a), .op_b(op_b), .rs1(rs1), .rs2(rs2), .pc(pc),
      .imm(imm), .out_valid(out_valid), .result(result), .reg_wr(reg_wr),
      .pc_src(pc_src), .target(target), .clear(clear)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // present an op on the inputs (in_valid high); no clock advance
   task automatic set_op(input logic [6:0] opc, input logic [2:0] fn3, input logic m,
                         input logic [2:0] aop, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] p, input logic [31:0] im);
      opcode = opc; f3 = fn3; m_ext = m; alu_op = aop; sign = sg;
      op_a = a; op_b = b; rs1 = r1; rs2 = r2; pc = p; imm = im;
      in_valid = 1'b1;
   endtask

   // present an op for one clock edge, then drop in_valid (1 ns after edge)
   task automatic issue(input logic [6:0] opc, input logic [2:0] fn3, input logic m,
                        input logic [2:0] aop, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] p, input logic [31:0] im);
      set_op(opc, fn3, m, aop, sg, a, b, r1, r2, p, im);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, reg_wr, pc_src, clear} !== 5'b01000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 01000 (ov,rdy,wr,pcs,clr)",
                  {out_valid, in_ready, reg_wr, pc_src, clear});
      end
      checks++;
      if (result !== 32'h0 || target !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: result=%h target=%h expected 0/0", result, target);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      logic [2:0]  aops [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0};
      logic [6:0]  opcs [10] = '{OPC_OP, OPC_OP, OPC_OP, OPC_OP, OPC_OP, OPC_OP, OPC_OP,
                                 OPC_OP, OPC_LUI, OPC_AUIPC};
      logic [31:0] av   [10] = '{32'h7, 32'h5, 32'h0000F0F0, 32'hF0, 32'hFC, 32'h1,
                                 32'h80000000, 32'h80000000, 32'h0, 32'h1000};
      logic [31:0] bv   [10] = '{32'hFFFFFFFF, 32'h7, 32'h00000FF0, 32'h0F, 32'h3F, 32'h21,
                                 32'h24, 32'h4, 32'h0, 32'h2000};
      logic [31:0] imv  [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h12345000, 32'h2000};
      logic [31:0] ev   [10] = '{32'h6, 32'hFFFFFFFE, 32'h0000FF00, 32'hFF, 32'h3C, 32'h2,
                                 32'h08000000, 32'hF8000000, 32'h12345000, 32'h3000};
      for (int i = 0; i < 10; i++) begin
         issue(opcs[i], 3'b000, 1'b0, aops[i], 1'b0, av[i], bv[i], 32'h0, 32'h0,
               av[i], imv[i]);
         checks++;
         if ({out_valid, reg_wr, pc_src, clear} !== 4'b1100 || result !== ev[i]) begin
            failures++;
            $display("FAIL alu[%0d]: ov/wr/pcs/clr=%b result=%h expected 1100 result=%h",
                     i, {out_valid, reg_wr, pc_src, clear}, result, ev[i]);
         end
      end
      // one cycle later: pulse gone, result held
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || reg_wr !== 1'b0 || result !== 32'h3000) begin
         failures++;
         $display("FAIL alu_hold: ov=%b wr=%b result=%h expected 0 0 00003000",
                  out_valid, reg_wr, result);
      end
   endtask

   task automatic test_branch();
      logic [2:0]  fv [8] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b100, 3'b101, 3'b111, 3'b010};
      logic        sv [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] r1 [8] = '{32'h5, 32'h5, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h5};
      logic [31:0] r2 [8] = '{32'h5, 32'h6, 32'h6, 32'h1, 32'h1, 32'h1, 32'h1, 32'h5};
      logic        tk [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         issue(OPC_BRANCH, fv[i], 1'b0, 3'd0, sv[i], 32'h100, 32'h20, r1[i], r2[i],
               32'h100, 32'h20);
         checks++;
         if ({out_valid, reg_wr, pc_src, clear} !== {1'b1, 1'b0, tk[i], tk[i]} ||
             target !== 32'h120) begin
            failures++;
            $display("FAIL branch[%0d]: ov/wr/pcs/clr=%b target=%h expected %b target=00000120",
                     i, {out_valid, reg_wr, pc_src, clear}, target,
                     {1'b1, 1'b0, tk[i], tk[i]});
         end
      end
   endtask

   task automatic test_muldiv();
      logic [2:0]  fv [11] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110,
                               3'b100, 3'b110, 3'b111, 3'b110};
      logic [31:0] av [11] = '{32'h80000000, 32'h00010001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h80000000, 32'h9, 32'h9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'h80000000};
      logic [31:0] bv [11] = '{32'h2, 32'h00010001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h0, 32'h0, 32'h2, 32'h2, 32'd7, 32'hFFFFFFFF};
      logic [31:0] ev [11] = '{32'hFFFFFFFF, 32'h00020001, 32'hFFFFFFFF, 32'hFFFFFFFE,
                               32'h80000000, 32'hFFFFFFFF, 32'h9, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'h2, 32'h0};
      int lat, n;
      for (int i = 0; i < 11; i++) begin
         lat = fv[i][2] ? DIV_LAT : MUL_LAT;
         issue(OPC_OP, fv[i], 1'b1, 3'd0, 1'b0, av[i], bv[i], av[i], bv[i], 32'h0, 32'h0);
         n = 0;
         while (out_valid !== 1'b1 && n < 100) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL md_busy[%0d]: in_ready=%b at cycle %0d expected 0", i, in_ready, n);
            end
            @(posedge clk); #1;
            n++;
         end
         checks++;
         if (n !== lat || result !== ev[i] || {in_ready, reg_wr, pc_src} !== 3'b110) begin
            failures++;
            $display("FAIL md[%0d]: latency=%0d result=%h rdy/wr/pcs=%b expected %0d %h 110",
                     i, n, result, {in_ready, reg_wr, pc_src}, lat, ev[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      issue(OPC_OP, 3'b000, 1'b1, 3'd0, 1'b0, 32'd3, 32'd5, 32'd3, 32'd5, 32'h0, 32'h0);
      while (out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== 32'd15) begin
         failures++;
         $display("FAIL b2b_mul: ov=%b rdy=%b result=%h expected 1 1 0000000f",
                  out_valid, in_ready, result);
      end
      // issue in the very cycle the multiply result is presented
      issue(OPC_OP, 3'b000, 1'b0, 3'd0, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd2) begin
         failures++;
         $display("FAIL b2b_add: ov=%b result=%h expected 1 00000002", out_valid, result);
      end
   endtask

   task automatic test_flush();
      int pulses = 0;
      issue(OPC_OP, 3'b101, 1'b1, 3'd0, 1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 32'h0, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_div: rdy=%b ov=%b expected 1 0", in_ready, out_valid);
      end
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL flush_quiet: %0d out_valid pulses after flush expected 0", pulses);
      end
      issue(OPC_OP, 3'b000, 1'b0, 3'd0, 1'b0, 32'd2, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd5) begin
         failures++;
         $display("FAIL flush_after_add: ov=%b result=%h expected 1 00000005", out_valid, result);
      end
      // flush together with a presented op: the op is dropped
      set_op(OPC_OP, 3'b000, 1'b0, 3'd0, 1'b0, 32'd10, 32'd10, 32'h0, 32'h0, 32'h0, 32'h0);
      flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'd5 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_accept: ov=%b result=%h rdy=%b expected 0 00000005 1",
                  out_valid, result, in_ready);
      end
   endtask

   task automatic test_jump();
      issue(OPC_JAL, 3'b000, 1'b0, 3'd0, 1'b0, 32'h1000, 32'h4, 32'h0, 32'h0,
            32'h1000, 32'hFFFFFFF8);
      checks++;
      if ({out_valid, reg_wr, pc_src, clear} !== 4'b1111 || target !== 32'h0FF8 ||
          result !== 32'h1004) begin
         failures++;
         $display("FAIL jal: ov/wr/pcs/clr=%b target=%h result=%h expected 1111 00000ff8 00001004",
                  {out_valid, reg_wr, pc_src, clear}, target, result);
      end
      issue(OPC_STORE, 3'b010, 1'b0, 3'd0, 1'b0, 32'h100, 32'h8, 32'h100, 32'h0,
            32'h2000, 32'h8);
      checks++;
      if ({out_valid, reg_wr, pc_src, clear} !== 4'b1000 || result !== 32'h108) begin
         failures++;
         $display("FAIL store: ov/wr/pcs/clr=%b result=%h expected 1000 00000108",
                  {out_valid, reg_wr, pc_src, clear}, result);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      // leave a nonzero result/target behind so the reset clear is visible
      issue(OPC_OP, 3'b000, 1'b0, 3'd0, 1'b0, 32'd20, 32'd22, 32'h0, 32'h0, 32'h0, 32'h40);
      issue(OPC_OP, 3'b100, 1'b1, 3'd0, 1'b0, 32'd50, 32'd5, 32'd50, 32'd5, 32'h0, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, reg_wr, pc_src, clear} !== 5'b01000 ||
          result !== 32'h0 || target !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid: ctrl=%b result=%h target=%h expected 01000 0 0",
                  {out_valid, in_ready, reg_wr, pc_src, clear}, result, target);
      end
      #2;
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL reset_quiet: %0d out_valid pulses after reset expected 0", pulses);
      end
      issue(OPC_JALR, 3'b000, 1'b0, 3'd0, 1'b0, 32'h203, 32'h4, 32'h203, 32'h0,
            32'h400, 32'h4);
      checks++;
      if ({out_valid, reg_wr, pc_src, clear} !== 4'b1111 || target !== 32'h206 ||
          result !== 32'h404) begin
         failures++;
         $display("FAIL jalr: ov/wr/pcs/clr=%b target=%h result=%h expected 1111 00000206 00000404",
                  {out_valid, reg_wr, pc_src, clear}, target, result);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_muldiv();
      test_back_to_back();
      test_flush();
      test_jump();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
